// File: rtl/lut_pkg.sv
// Shared types and constants for the LUT loader: FSM state encoding,
// table geometry and the power-on default fill pattern.
package lut_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } lut_state_e;

  // Table geometry
  localparam int LUT_DEPTH = 32;
  localparam int LUT_WIDTH = 8;

  // Default fill: the first LUT_DEFAULT_CNT entries count up from
  // LUT_DEFAULT_BASE, the rest of the table is zero.
  localparam int LUT_DEFAULT_BASE = 60;
  localparam int LUT_DEFAULT_CNT  = 16;

endpackage

// File: rtl/lut_ram.sv
// Table storage for the LUT loader: one write port and one registered
// read port. A read and a write to the same address in the same cycle
// return the value held before the write.
module lut_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata_p1;

  // Storage write; contents are data, so reset does not touch them
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; samples the array before this cycle's write lands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_p1 <= '0;
    end else begin
      r_rdata_p1 <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/lut_loader.sv
// LUT loader: after reset fills a 32-entry table with defaults, then
// accepts load sessions (start + base/count) that stream bytes into
// consecutive addresses, wrapping at the top of the table.
// Optional feature: define LUT_LOADER_CHECKSUM_EN to add an 8-bit
// running checksum output of the bytes written in the last session.
module lut_loader
  import lut_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int WIDTH = LUT_WIDTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CW-1:0]    count,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef LUT_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  // Requests above the table size are saturated to a full-table load
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    if (c > CW'(DEPTH)) begin
      return CW'(DEPTH);
    end
    return c;
  endfunction

  // Power-on default value for a given table index
  function automatic logic [WIDTH-1:0] default_entry(input logic [AW-1:0] idx);
    if (int'(idx) < LUT_DEFAULT_CNT) begin
      return WIDTH'(LUT_DEFAULT_BASE) + WIDTH'(idx);
    end
    return '0;
  endfunction

  lut_state_e       r_state;
  lut_state_e       w_next_state;
  logic [AW-1:0]    r_init_cnt;
  logic [AW-1:0]    r_addr;
  logic [CW-1:0]    r_remaining;
  logic             r_err;

  logic             w_start_ok;
  logic             w_beat;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;

  assign w_start_ok = start && (r_state == ST_IDLE);
  assign w_beat     = wr_valid && (r_state == ST_LOAD);

  assign wr_ready = (r_state == ST_LOAD);
  assign busy     = (r_state == ST_INIT) || (r_state == ST_LOAD);
  assign done     = (r_state == ST_DONE);
  assign err      = r_err;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: fill, wait for start, stream beats, pulse done
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_INIT: begin
        if (r_init_cnt == AW'(DEPTH - 1)) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (start) begin
          w_next_state = (count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_beat && (r_remaining == CW'(1))) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase
  end

  // Default-fill counter; wraps back to 0 as INIT completes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + AW'(1);
    end
  end

  // Session address and remaining-beat counter; address wraps mod DEPTH
  // (DEPTH is a power of two, so the natural overflow is the wrap)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_start_ok) begin
      r_addr      <= base_addr;
      r_remaining <= clamp_count(count);
    end else if (w_beat) begin
      r_addr      <= r_addr + AW'(1);
      r_remaining <= r_remaining - CW'(1);
    end
  end

  // Sticky error: a start outside IDLE is dropped and flagged
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (start) begin
      r_err <= !w_start_ok;
    end
  end

  // Table write port: default fill in INIT, streamed bytes in LOAD
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_addr;
    w_wdata = wr_data;
    if (r_state == ST_INIT) begin
      w_we    = !reset;
      w_waddr = r_init_cnt;
      w_wdata = default_entry(r_init_cnt);
    end else if (r_state == ST_LOAD) begin
      w_we    = w_beat && !reset;
    end
  end

  lut_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;

  // Running mod-256 sum of accepted bytes, cleared by each accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_beat) begin
      r_checksum <= r_checksum + wr_data;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_lut_loader.sv
// Directed testbench for lut_loader: default fill, wrapped loads,
// stalled loads, error flag, zero/over-size counts and mid-load reset.
// Read data is scored against a reference table through an expected queue.
module tb_lut_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] count;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       err;
`ifdef LUT_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model [32];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  lut_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef LUT_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_pop(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty expected queue, required one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, rd_data, e);
    end
  endtask

  task automatic read_addr(input logic [4:0] a);
    rd_addr = a;
    exp_q.push_back(model[a]);
    step();
    rd_pop("rd_data");
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      read_addr(5'(i));
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 32; i++) begin
      model[i] = (i < 16) ? 8'(60 + i) : 8'h00;
    end
  endtask

  // Reset has just been released: 31 edges keep INIT busy, the 32nd ends it
  task automatic wait_init();
    for (int i = 0; i < 31; i++) begin
      step();
    end
    check("busy_init_31", busy, 1);
    step();
    check("busy_init_32", busy, 0);
    check("wr_ready_idle", wr_ready, 0);
  endtask

  task automatic do_session(input logic [4:0] b, input int cnt, input logic [7:0] seed,
                            input bit toggle, input bit poke, input int abort_after);
    int         eff;
    int         beats;
    int         cycles;
    bit         v;
    logic [4:0] wa;
`ifdef LUT_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    eff       = (cnt > 32) ? 32 : cnt;
    start     = 1'b1;
    base_addr = b;
    count     = 6'(cnt);
    step();
    start = 1'b0;
    check("err_clear_on_start", err, 0);
    if (eff == 0) begin
      check("done_cnt0", done, 1);
      check("wr_ready_cnt0", wr_ready, 0);
      step();
      check("done_cnt0_after", done, 0);
      return;
    end
    beats  = 0;
    cycles = 0;
    while (beats < eff && cycles < 200) begin
      check("wr_ready_load", wr_ready, 1);
      check("busy_load", busy, 1);
      check("done_load", done, 0);
      if (abort_after >= 0 && beats == abort_after) begin
        wr_valid = 1'b0;
        return;
      end
      v        = !toggle || (cycles % 2 == 1);
      wa       = 5'(int'(b) + beats);
      wr_valid = v;
      wr_data  = seed + 8'(beats);
      start    = poke && (beats == 1) && v;
      rd_addr  = wa;
      exp_q.push_back(model[wa]);
      if (v) begin
        model[wa] = wr_data;
`ifdef LUT_LOADER_CHECKSUM_EN
        sum = sum + wr_data;
`endif
      end
      step();
      rd_pop("rd_before_write");
      if (start) begin
        check("err_set_in_load", err, 1);
      end
      start = 1'b0;
      if (v) beats++;
      cycles++;
    end
    wr_valid = 1'b0;
    if (beats != eff) begin
      n_checks++;
      n_errors++;
      $error("FAIL beat_budget: observed %0d beats expected %0d", beats, eff);
    end
    check("done_pulse", done, 1);
    check("wr_ready_done", wr_ready, 0);
    check("busy_done", busy, 0);
    if (poke) begin
      check("err_sticky", err, 1);
    end
`ifdef LUT_LOADER_CHECKSUM_EN
    check("checksum", checksum, sum);
`endif
    step();
    check("done_after", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_addr   = '0;
    step();
    step();
    step();
    check("rst_busy", busy, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_data", rd_data, 0);

    // Default fill
    reset = 1'b0;
    init_model();
    wait_init();
    read_addr(5'd0);
    read_addr(5'd15);
    read_addr(5'd16);
    read_addr(5'd31);
    check("default_15", model[15], 8'd75);

    // Wrapped load: 30,31,0,1 <- A1..A4, checksum 0x8A
    do_session(5'd30, 4, 8'hA1, 1'b0, 1'b0, -1);
    read_addr(5'd30);
    read_addr(5'd31);
    read_addr(5'd0);
    read_addr(5'd1);
    read_addr(5'd2);

    // Stalled load: valid every other cycle, exactly 3 writes
    do_session(5'd10, 3, 8'h33, 1'b1, 1'b0, -1);
    read_all();

    // Start during LOAD is ignored and flags err
    do_session(5'd5, 3, 8'h50, 1'b0, 1'b1, -1);
    read_addr(5'd20);

    // Zero count: done next cycle, no writes; also clears err
    do_session(5'd3, 0, 8'h00, 1'b0, 1'b0, -1);
    read_all();

    // Over-size count clamps to a full table
    do_session(5'd7, 40, 8'h80, 1'b0, 1'b0, -1);
    read_all();

    // Reset after 2 of 5 beats at base 0
    do_session(5'd0, 5, 8'hEE, 1'b0, 1'b0, 2);
    reset = 1'b1;
    step();
    check("midrst_busy", busy, 1);
    check("midrst_wr_ready", wr_ready, 0);
    check("midrst_rd_data", rd_data, 0);
    reset = 1'b0;
    init_model();
    wait_init();
    read_addr(5'd0);
    read_addr(5'd1);
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
